// File: rtl/de10_input_conditioner.sv
// de10_input_conditioner
//   Conditions the raw DE10-Lite slide switches and pushbuttons before any
//   design-level block sees them. Every bit is synchronized and debounced.
//   The block produces clean levels, one-cycle key press/release pulses and
//   a registered design-select code.
//
// Ports
//   MAX10_CLK1_50  in   1   system clock (50 MHz)
//   RESET_N        in   1   asynchronous active-low reset
//   SW             in   10  raw slide switches
//   KEY            in   2   raw pushbuttons, active-low
//   SW_CLEAN       out  10  debounced switch levels
//   KEY_LEVEL      out  2   debounced key state, 1 = pressed
//   KEY_PRESS      out  2   one-cycle pulse per accepted press (plus repeats)
//   KEY_RELEASE    out  2   one-cycle pulse per accepted release
//   MODE           out  2   design select 0/1/2 decoded from SW_CLEAN[9:8]
//   MODE_CHANGE    out  1   one-cycle pulse when MODE takes a new value
//
// Build option
//   KEY_AUTOREPEAT_EN  when defined, a held key re-pulses KEY_PRESS after
//                      REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.

// One synchronizer + debouncer lane. Output is in the active-high domain;
// ACTIVE_LOW lanes idle at 1 on the pin and are inverted after the sync chain.
module de10_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    sync_lvl = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Any cycle where sync agrees with stable restarts the window, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches the output. The
    // counter stops at DEBOUNCE_CYCLES-1 and never wraps.
    if (sync_lvl != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_lvl;
        rise_d   = sync_lvl;
        fall_d   = ~sync_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{ACTIVE_LOW}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

module de10_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET_N,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] SW_CLEAN,
  output logic [1:0] KEY_LEVEL,
  output logic [1:0] KEY_PRESS,
  output logic [1:0] KEY_RELEASE,
  output logic [1:0] MODE,
  output logic       MODE_CHANGE
);
  // Lanes 0..9 are switches, 10..11 are keys.
  localparam int NUM_LANES = 12;

  logic [NUM_LANES-1:0] raw, lvl, rise, fall;
  logic [1:0]           key_lvl;

  assign raw     = {KEY, SW};
  assign key_lvl = lvl[11:10];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    de10_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (i >= 10)
    ) u_lane (
      .clk   (MAX10_CLK1_50),
      .rst_n (RESET_N),
      .raw   (raw[i]),
      .level (lvl[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Switch lanes only feed levels; their edge pulses have no consumer.
  logic unused_sw_edges;
  assign unused_sw_edges = &{1'b0, rise[9:0], fall[9:0]};

  // Mode decode: registered one cycle behind SW_CLEAN.
  logic [1:0] mode_q, mode_d;
  logic       mode_chg_q, mode_chg_d;

  always_comb begin
    unique case (lvl[9:8])
      2'b00:   mode_d = 2'd0;
      2'b01:   mode_d = 2'd1;
      default: mode_d = 2'd2;
    endcase
    // 10<->11 decodes to the same mode, so no pulse.
    mode_chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q     <= 2'd0;
      mode_chg_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // hold counts cycles since the last press/repeat pulse; phase selects
  // whether the first (delay) or subsequent (period) interval is running.
  logic [1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]             phase_q, phase_d;
  logic [1:0]             rep_q, rep_d;

  always_comb begin
    hold_d  = hold_q;
    phase_d = phase_q;
    rep_d   = '0;
    for (int k = 0; k < 2; k++) begin
      if (!key_lvl[k]) begin
        hold_d[k]  = '0;
        phase_d[k] = 1'b0;
      end else if ((!phase_q[k] && hold_q[k] == HOLD_W'(REPEAT_DELAY - 1)) ||
                   ( phase_q[k] && hold_q[k] == HOLD_W'(REPEAT_PERIOD - 1))) begin
        hold_d[k]  = '0;
        phase_d[k] = 1'b1;
        rep_d[k]   = 1'b1;
      end else begin
        hold_d[k] = hold_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_q  <= '0;
      phase_q <= '0;
      rep_q   <= '0;
    end else begin
      hold_q  <= hold_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
    end
  end

  // A repeat that lands on the release cycle is dropped.
  assign KEY_PRESS = rise[11:10] | (rep_q & key_lvl);
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign KEY_PRESS = rise[11:10];
`endif

  assign SW_CLEAN    = lvl[9:0];
  assign KEY_LEVEL   = key_lvl;
  assign KEY_RELEASE = fall[11:10];
  assign MODE        = mode_q;
  assign MODE_CHANGE = mode_chg_q;
endmodule
